// File: rtl/transmitter.sv
// rtl/transmitter.sv - 802.11a-style serial bit generator: "1100" preamble, zero gap, rate-1/2 K=7 coded data.
// Optional macro TX_SCRAMBLER_EN: whiten data with x^7+x^4+1 before the convolutional encoder.
module transmitter #(
   parameter int PREAMBLE_BITS = 192,
   parameter int GAP_BITS      = 48,
   parameter int DATA_BITS     = 192
`ifdef TX_SCRAMBLER_EN
   ,
   parameter logic [6:0] SCR_SEED = 7'b1011101
`endif
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Start,
   input  logic Input,
   output logic Output
);

   localparam int MAX_LEN_PG = (PREAMBLE_BITS > GAP_BITS) ? PREAMBLE_BITS : GAP_BITS;
   localparam int MAX_LEN    = (MAX_LEN_PG > 2 * DATA_BITS) ? MAX_LEN_PG : 2 * DATA_BITS;
   localparam int CNT_W      = (MAX_LEN < 4) ? 3 : $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(2 * DATA_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      GAP      = 2'd2,
      DATA     = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [5:0]       hist_q;
   logic             b_hold_q;
   logic             out_q;

   logic             data_bit;
   logic             a_bit_d;
   logic             b_bit_d;
   logic [5:0]       hist_d;

`ifdef TX_SCRAMBLER_EN
   logic [6:0]       scr_q;
   logic [6:0]       scr_d;
   logic             scr_fb;

   always_comb begin
      scr_fb   = scr_q[6] ^ scr_q[3];
      scr_d    = {scr_q[5:0], scr_fb};
      data_bit = Input ^ scr_fb;
   end
`else
   always_comb begin
      data_bit = Input;
   end
`endif

   // hist_q[0] is d1 (most recent previous bit), hist_q[5] is d6.
   always_comb begin
      a_bit_d = data_bit ^ hist_q[1] ^ hist_q[2] ^ hist_q[4] ^ hist_q[5];
      b_bit_d = data_bit ^ hist_q[0] ^ hist_q[1] ^ hist_q[2] ^ hist_q[5];
      hist_d  = {hist_q[4:0], data_bit};
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hist_q   <= '0;
         b_hold_q <= 1'b0;
         out_q    <= 1'b0;
`ifdef TX_SCRAMBLER_EN
         scr_q    <= SCR_SEED;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               hist_q   <= '0;
               b_hold_q <= 1'b0;
`ifdef TX_SCRAMBLER_EN
               scr_q    <= SCR_SEED;
`endif
               // The accept edge already carries preamble bit 0, so counting resumes at 1.
               if (Start) begin
                  state_q <= PREAMBLE;
                  cnt_q   <= CNT_ONE;
                  out_q   <= 1'b1;
               end else begin
                  cnt_q   <= '0;
                  out_q   <= 1'b0;
               end
            end

            PREAMBLE: begin
               out_q <= ~cnt_q[1];
               if (cnt_q == PRE_LAST) begin
                  cnt_q   <= '0;
                  state_q <= (GAP_BITS > 0) ? GAP : DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            GAP: begin
               out_q <= 1'b0;
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            DATA: begin
               if (!cnt_q[0]) begin
                  out_q    <= a_bit_d;
                  b_hold_q <= b_bit_d;
                  hist_q   <= hist_d;
`ifdef TX_SCRAMBLER_EN
                  scr_q    <= scr_d;
`endif
               end else begin
                  out_q <= b_hold_q;
               end
               if (cnt_q == DATA_LAST) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               out_q   <= 1'b0;
            end
         endcase
      end
   end

   assign Output = out_q;

endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - scoreboard bench for transmitter (preamble, gap, coded data, restart, abort).
module tb_transmitter;

   localparam int PB        = 192;
   localparam int GB        = 48;
   localparam int DB        = 192;
   localparam int FRAME_LEN = PB + GB + 2 * DB;
`ifdef TX_SCRAMBLER_EN
   localparam bit SCR_ON = 1'b1;
`else
   localparam bit SCR_ON = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   logic Start = 1'b0;
   logic Input = 1'b0;
   logic Output;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   exp_q[$];
   bit   frame_in[DB];
   bit   frame_exp[FRAME_LEN];

   transmitter dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .Input  (Input),
      .Output (Output)
   );

   always #5 Clock = ~Clock;

   task automatic check_bit(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic rst, input logic st, input logic din, input string tag);
      bit e;
      @(negedge Clock);
      Reset = rst;
      Start = st;
      Input = din;
      @(posedge Clock);
      #1;
      e = exp_q.pop_front();
      check_bit(tag, Output, e);
   endtask

   task automatic idle(input int n, input logic st_rst, input string tag);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(1'b0);
         cycle(st_rst, st_rst, 1'($urandom), $sformatf("%s[%0d]", tag, i));
      end
   endtask

   // Reference: generator taps applied to the window {b, d1..d6}, b in the MSB.
   task automatic build_frame(input int mode);
      bit [6:0] s;
      bit [5:0] h;
      bit [6:0] w;
      bit       fb;
      bit       b;
      for (int n = 0; n < DB; n++) begin
         case (mode)
            0:       frame_in[n] = 1'b0;
            1:       frame_in[n] = (n == 0);
            default: frame_in[n] = 1'($urandom);
         endcase
      end
      for (int k = 0; k < PB; k++) frame_exp[k] = ((k % 4) < 2);
      for (int k = 0; k < GB; k++) frame_exp[PB + k] = 1'b0;
      s = 7'b1011101;
      h = '0;
      for (int n = 0; n < DB; n++) begin
         fb = s[6] ^ s[3];
         s  = {s[5:0], fb};
         b  = frame_in[n] ^ (SCR_ON & fb);
         w  = {b, h};
         frame_exp[PB + GB + 2 * n]     = ^(w & 7'o133);
         frame_exp[PB + GB + 2 * n + 1] = ^(w & 7'o171);
         h  = w[6:1];
      end
   endtask

   task automatic run_frame(input int mode, input bit hold_start, input int regap_at,
                            input int abort_at, input string tag);
      logic st;
      logic din;
      logic rst;
      int   dc;
      build_frame(mode);
      for (int c = 0; c < FRAME_LEN; c++) begin
         st  = (c == 0) || hold_start || (c == regap_at);
         rst = (c == abort_at);
         dc  = c - PB - GB;
         if (dc >= 0 && (dc % 2) == 0) din = frame_in[dc / 2];
         else                          din = 1'($urandom);
         exp_q.push_back(rst ? 1'b0 : frame_exp[c]);
         cycle(rst, st, din, $sformatf("%s bit%0d", tag, c));
         if (rst) return;
      end
   endtask

   initial begin
      idle(3, 1'b1, "reset");
      idle(10, 1'b0, "idle_after_reset");

      run_frame(0, 1'b0, -1, -1, "zero_data");
      idle(5, 1'b0, "idle_after_zero");

      run_frame(1, 1'b0, -1, -1, "impulse");
      idle(3, 1'b0, "idle_after_impulse");

      run_frame(2, 1'b0, PB + 10, -1, "restart_in_gap");
      idle(4, 1'b0, "idle_after_regap");

      run_frame(2, 1'b1, -1, -1, "start_held");
      run_frame(0, 1'b0, -1, -1, "back_to_back");
      idle(3, 1'b0, "idle_after_b2b");

      run_frame(2, 1'b0, -1, PB + GB + 61, "abort");
      idle(3, 1'b0, "idle_after_abort");
      idle(2, 1'b1, "reset_with_start");
      run_frame(0, 1'b0, -1, -1, "after_abort");
      idle(5, 1'b0, "idle_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
